// File: rtl/matrix_loader_pkg.sv
// Shared types and sizing for the matrix frame loader.
// MATRIX_LOADER_CKSUM_EN selects the 19-byte checksummed frame.
package matrix_loader_pkg;

    localparam int MAT_ELEMS = 9;
    localparam int ELEM_W    = 8;
    localparam int MAT_W     = MAT_ELEMS * ELEM_W;

`ifdef MATRIX_LOADER_CKSUM_EN
    localparam int FRAME_LEN = 19;
`else
    localparam int FRAME_LEN = 18;
`endif

    typedef enum logic [2:0] {
        ST_FILL_A = 3'd0,
        ST_FILL_B = 3'd1,
        ST_CKSUM  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4
    } state_e;

endpackage

// File: rtl/matrix_frame_loader_if.sv
// Byte-stream and multiplier-side signals of the matrix frame loader.
// slave = loader side, master = stream source / multiplier / observer side.
interface matrix_frame_loader_if;
    import matrix_loader_pkg::*;

    logic                  in_valid;
    logic [ELEM_W-1:0]     in_data;
    logic                  in_first;
    logic                  in_ready;
    logic                  mult_start;
    logic [MAT_W-1:0]      matrix_a;
    logic [MAT_W-1:0]      matrix_b;
    logic                  mult_valid;
    logic                  busy;
    logic [7:0]            frame_cnt;
    logic                  err_timeout;
    logic                  err_cksum;

    modport slave (
        input  in_valid, in_data, in_first, mult_valid,
        output in_ready, mult_start, matrix_a, matrix_b, busy,
               frame_cnt, err_timeout, err_cksum
    );

    modport master (
        output in_valid, in_data, in_first, mult_valid,
        input  in_ready, mult_start, matrix_a, matrix_b, busy,
               frame_cnt, err_timeout, err_cksum
    );

endinterface

// File: rtl/matrix_frame_loader.sv
// Packs a byte stream into two 3x3 operands, pulses mult_start, holds operands until mult_valid.
// Latency: mult_start the cycle after the last frame byte; watchdog of TIMEOUT_CYCLES in WAIT.
// Backpressure: in_ready low in ISSUE/WAIT; 1 byte/cycle while filling. MATRIX_LOADER_CKSUM_EN adds an XOR byte.
module matrix_frame_loader
    import matrix_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_frame_loader_if.slave  bus
);

    localparam int              WD_W     = 6;
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_IDX = 4'(MAT_ELEMS - 1);

    state_e            state;
    logic              armed;
    logic [3:0]        idx;
    logic [WD_W-1:0]   wd_cnt;
    logic [MAT_W-1:0]  mat_a;
    logic [MAT_W-1:0]  mat_b;
    logic              mult_start_q;
    logic              busy_q;
    logic [7:0]        frame_cnt_q;
    logic              err_timeout_q;
    logic              fill_st;
    logic              accept;
`ifdef MATRIX_LOADER_CKSUM_EN
    logic [ELEM_W-1:0] ck_acc;
    logic              err_cksum_q;
`endif

    // armed keeps in_ready low while reset is asserted
    assign fill_st = armed && (state == ST_FILL_A || state == ST_FILL_B || state == ST_CKSUM);
    assign accept  = fill_st && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_FILL_A;
            armed         <= 1'b0;
            idx           <= '0;
            wd_cnt        <= '0;
            mat_a         <= '0;
            mat_b         <= '0;
            mult_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
`ifdef MATRIX_LOADER_CKSUM_EN
            ck_acc        <= '0;
            err_cksum_q   <= 1'b0;
`endif
        end else begin
            armed         <= 1'b1;
            mult_start_q  <= 1'b0;
            err_timeout_q <= 1'b0;
`ifdef MATRIX_LOADER_CKSUM_EN
            err_cksum_q   <= 1'b0;
`endif
            case (state)
                ST_FILL_A, ST_FILL_B, ST_CKSUM: begin
                    if (accept) begin
                        if (bus.in_first) begin
                            mat_a[ELEM_W-1:0] <= bus.in_data;
                            idx               <= 4'd1;
                            state             <= ST_FILL_A;
`ifdef MATRIX_LOADER_CKSUM_EN
                            ck_acc            <= bus.in_data;
`endif
                        end else if (state == ST_FILL_A) begin
                            mat_a[int'(idx)*ELEM_W +: ELEM_W] <= bus.in_data;
`ifdef MATRIX_LOADER_CKSUM_EN
                            ck_acc <= (idx == '0) ? bus.in_data : (ck_acc ^ bus.in_data);
`endif
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= ST_FILL_B;
                            end else begin
                                idx   <= idx + 1'b1;
                            end
                        end else if (state == ST_FILL_B) begin
                            mat_b[int'(idx)*ELEM_W +: ELEM_W] <= bus.in_data;
`ifdef MATRIX_LOADER_CKSUM_EN
                            ck_acc <= ck_acc ^ bus.in_data;
`endif
                            if (idx == LAST_IDX) begin
                                idx <= '0;
`ifdef MATRIX_LOADER_CKSUM_EN
                                state        <= ST_CKSUM;
`else
                                state        <= ST_ISSUE;
                                mult_start_q <= 1'b1;
                                busy_q       <= 1'b1;
                                wd_cnt       <= '0;
`endif
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
`ifdef MATRIX_LOADER_CKSUM_EN
                            // bad checksum keeps the received operands visible for debug
                            if (bus.in_data == ck_acc) begin
                                state        <= ST_ISSUE;
                                mult_start_q <= 1'b1;
                                busy_q       <= 1'b1;
                                wd_cnt       <= '0;
                            end else begin
                                err_cksum_q  <= 1'b1;
                                state        <= ST_FILL_A;
                            end
`else
                            state <= ST_FILL_A;
`endif
                        end
                    end
                end
                ST_ISSUE: begin
                    state  <= ST_WAIT;
                    wd_cnt <= wd_cnt + 1'b1;
                end
                ST_WAIT: begin
                    if (bus.mult_valid) begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        state       <= ST_FILL_A;
                        busy_q      <= 1'b0;
                    end else if (wd_cnt == WD_LAST) begin
                        err_timeout_q <= 1'b1;
                        state         <= ST_FILL_A;
                        busy_q        <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_FILL_A;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = fill_st;
    assign bus.mult_start  = mult_start_q;
    assign bus.matrix_a    = mat_a;
    assign bus.matrix_b    = mat_b;
    assign bus.busy        = busy_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.err_timeout = err_timeout_q;
`ifdef MATRIX_LOADER_CKSUM_EN
    assign bus.err_cksum   = err_cksum_q;
`else
    assign bus.err_cksum   = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Directed bench for matrix_frame_loader with a fixed 8-cycle model multiplier.
// Covers MATRIX_LOADER_CKSUM_EN scenarios when that macro is defined.
module tb_matrix_frame_loader;
    import matrix_loader_pkg::*;

    localparam int TO = 32;
    localparam logic [71:0] A_ID  = 72'h01_00_00_00_01_00_00_00_01;
    localparam logic [71:0] B_SEQ = 72'h09_08_07_06_05_04_03_02_01;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    matrix_frame_loader_if bus();

    matrix_frame_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_starts = 0;
    int n_ck = 0;
    int dly = 0;
    bit resp_en = 1'b1;
    logic model_valid = 1'b0;
    logic spur_valid = 1'b0;
    logic [7:0] exp_frames = 8'd0;
`ifdef MATRIX_LOADER_CKSUM_EN
    bit ck_flip = 1'b0;
`endif

    assign bus.mult_valid = model_valid | spur_valid;

    always @(posedge clk) cyc <= cyc + 1;

    // model multiplier: valid_out 8 cycles after each observed start
    always @(negedge clk) begin
        if (!rst_n) begin
            dly = 0;
            model_valid = 1'b0;
        end else begin
            model_valid = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0) model_valid = 1'b1;
            end
            if (bus.mult_start) begin
                n_starts++;
                if (resp_en) dly = 8;
            end
            if (bus.err_cksum) n_ck++;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic f);
        bit acc;
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_first = f;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            acc = (bus.in_ready === 1'b1);
            @(posedge clk);
            n++;
            if (!acc) @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_byte accept: got no accept within %0d cycles, want accept", n);
        end
    endtask

    task automatic send_frame(input logic [71:0] a, input logic [71:0] b, input bit gaps, input bit spur);
        logic [7:0] d;
`ifdef MATRIX_LOADER_CKSUM_EN
        logic [7:0] ck;
        ck = 8'h00;
`endif
        for (int i = 0; i < 18; i++) begin
            d = (i < 9) ? a[i*8 +: 8] : b[(i-9)*8 +: 8];
`ifdef MATRIX_LOADER_CKSUM_EN
            ck ^= d;
`endif
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            if (spur && i == 12) begin
                spur_valid = 1'b1;
                @(negedge clk);
                spur_valid = 1'b0;
            end
            send_byte(d, i == 0);
        end
`ifdef MATRIX_LOADER_CKSUM_EN
        send_byte(ck ^ {7'd0, ck_flip}, 1'b0);
`endif
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: in_ready=%b after %0d cycles, want 1", bus.in_ready, n);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_first = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.mult_start !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset start/busy: got %b/%b want 0/0", bus.mult_start, bus.busy); end
        checks++; if (bus.matrix_a !== 72'd0 || bus.matrix_b !== 72'd0) begin errors++; $display("FAIL reset matrices: got %h/%h want 0", bus.matrix_a, bus.matrix_b); end
        checks++; if (bus.frame_cnt !== 8'd0) begin errors++; $display("FAIL reset frame_cnt: got %0d want 0", bus.frame_cnt); end
        checks++; if (bus.err_timeout !== 1'b0 || bus.err_cksum !== 1'b0) begin errors++; $display("FAIL reset errs: got %b/%b want 0/0", bus.err_timeout, bus.err_cksum); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int s0, n;
        s0 = n_starts;
        send_frame(A_ID, B_SEQ, 1'b0, 1'b0);
        checks++; if (bus.mult_start !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic issue: start/busy/rdy got %b/%b/%b want 1/1/0", bus.mult_start, bus.busy, bus.in_ready); end
        checks++; if (bus.matrix_a !== A_ID) begin errors++; $display("FAIL basic matrix_a: got %h want %h", bus.matrix_a, A_ID); end
        checks++; if (bus.matrix_b !== B_SEQ) begin errors++; $display("FAIL basic matrix_b: got %h want %h", bus.matrix_b, B_SEQ); end
        wait_done(n);
        exp_frames++;
        checks++; if (n != 9) begin errors++; $display("FAIL basic ready latency: got %0d want 9", n); end
        checks++; if (bus.frame_cnt !== exp_frames) begin errors++; $display("FAIL basic frame_cnt: got %0d want %0d", bus.frame_cnt, exp_frames); end
        checks++; if (n_starts - s0 != 1) begin errors++; $display("FAIL basic start count: got %0d want 1", n_starts - s0); end
        checks++; if (bus.matrix_a !== A_ID) begin errors++; $display("FAIL basic hold matrix_a: got %h want %h", bus.matrix_a, A_ID); end
    endtask

    task automatic test_resync();
        int s0, n;
        bit early;
`ifdef MATRIX_LOADER_CKSUM_EN
        logic [7:0] ck;
        ck = 8'hAA;
`endif
        s0 = n_starts;
        early = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), i == 0);
        send_byte(8'hAA, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            if (bus.mult_start !== 1'b0) early = 1'b1;
            send_byte(8'(k), 1'b0);
`ifdef MATRIX_LOADER_CKSUM_EN
            ck ^= 8'(k);
`endif
        end
`ifdef MATRIX_LOADER_CKSUM_EN
        if (bus.mult_start !== 1'b0) early = 1'b1;
        send_byte(ck, 1'b0);
`endif
        checks++; if (early || n_starts != s0) begin errors++; $display("FAIL resync early start: got %0d starts want 0", n_starts - s0); end
        checks++; if (bus.mult_start !== 1'b1) begin errors++; $display("FAIL resync start: got %b want 1", bus.mult_start); end
        checks++; if (bus.matrix_a !== 72'h08_07_06_05_04_03_02_01_AA) begin errors++; $display("FAIL resync matrix_a: got %h want 080706050403020 1AA", bus.matrix_a); end
        checks++; if (bus.matrix_b !== 72'h11_10_0F_0E_0D_0C_0B_0A_09) begin errors++; $display("FAIL resync matrix_b: got %h want 11100F0E0D0C0B0A09", bus.matrix_b); end
        wait_done(n);
        exp_frames++;
        checks++; if (bus.frame_cnt !== exp_frames || n_starts - s0 != 1) begin errors++; $display("FAIL resync frame_cnt/starts: got %0d/%0d want %0d/1", bus.frame_cnt, n_starts - s0, exp_frames); end
    endtask

    task automatic test_timeout();
        int t0, n;
        resp_en = 1'b0;
        send_frame({9{8'h55}}, {9{8'h3C}}, 1'b0, 1'b0);
        checks++; if (bus.mult_start !== 1'b1) begin errors++; $display("FAIL timeout start: got %b want 1", bus.mult_start); end
        t0 = cyc;
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.err_timeout !== 1'b1 || cyc - t0 != TO) begin errors++; $display("FAIL timeout pulse delay: got %0d (seen=%b) want %0d", cyc - t0, bus.err_timeout, TO); end
        checks++; if (bus.frame_cnt !== exp_frames) begin errors++; $display("FAIL timeout frame_cnt: got %0d want %0d", bus.frame_cnt, exp_frames); end
        @(negedge clk);
        checks++; if (bus.err_timeout !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL timeout recovery: err/rdy/busy got %b/%b/%b want 0/1/0", bus.err_timeout, bus.in_ready, bus.busy); end
        resp_en = 1'b1;
    endtask

    task automatic test_gaps();
        int n;
        send_frame(A_ID, B_SEQ, 1'b1, 1'b1);
        checks++; if (bus.frame_cnt !== exp_frames) begin errors++; $display("FAIL gaps spurious frame_cnt: got %0d want %0d", bus.frame_cnt, exp_frames); end
        checks++; if (bus.matrix_a !== A_ID || bus.matrix_b !== B_SEQ) begin errors++; $display("FAIL gaps packing: got %h/%h want %h/%h", bus.matrix_a, bus.matrix_b, A_ID, B_SEQ); end
        wait_done(n);
        exp_frames++;
        checks++; if (bus.frame_cnt !== exp_frames) begin errors++; $display("FAIL gaps frame_cnt: got %0d want %0d", bus.frame_cnt, exp_frames); end
    endtask

`ifdef MATRIX_LOADER_CKSUM_EN
    task automatic test_cksum();
        int s0, c0, n;
        s0 = n_starts;
        ck_flip = 1'b0;
        send_frame(B_SEQ, A_ID, 1'b0, 1'b0);
        checks++; if (bus.mult_start !== 1'b1) begin errors++; $display("FAIL cksum good start: got %b want 1", bus.mult_start); end
        wait_done(n);
        exp_frames++;
        checks++; if (bus.frame_cnt !== exp_frames) begin errors++; $display("FAIL cksum good frame_cnt: got %0d want %0d", bus.frame_cnt, exp_frames); end
        s0 = n_starts;
        c0 = n_ck;
        ck_flip = 1'b1;
        send_frame(A_ID, B_SEQ, 1'b0, 1'b0);
        ck_flip = 1'b0;
        checks++; if (bus.err_cksum !== 1'b1 || bus.mult_start !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL cksum bad: err/start/rdy got %b/%b/%b want 1/0/1", bus.err_cksum, bus.mult_start, bus.in_ready); end
        checks++; if (bus.matrix_a !== A_ID || bus.matrix_b !== B_SEQ) begin errors++; $display("FAIL cksum bad retain: got %h/%h want %h/%h", bus.matrix_a, bus.matrix_b, A_ID, B_SEQ); end
        repeat (12) @(negedge clk);
        checks++; if (n_starts != s0 || n_ck - c0 != 1 || bus.frame_cnt !== exp_frames) begin errors++; $display("FAIL cksum bad counts: starts %0d pulses %0d frame_cnt %0d want 0 1 %0d", n_starts - s0, n_ck - c0, bus.frame_cnt, exp_frames); end
    endtask
`endif

    task automatic test_reset_wait();
        int n;
        send_frame(A_ID, B_SEQ, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstwait busy before reset: got %b want 1", bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.frame_cnt !== 8'd0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstwait async: busy/cnt/rdy got %b/%0d/%b want 0/0/0", bus.busy, bus.frame_cnt, bus.in_ready); end
        checks++; if (bus.matrix_a !== 72'd0 || bus.matrix_b !== 72'd0) begin errors++; $display("FAIL rstwait matrices: got %h/%h want 0", bus.matrix_a, bus.matrix_b); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 8'd0;
        @(negedge clk);
        send_frame(B_SEQ, A_ID, 1'b0, 1'b0);
        checks++; if (bus.mult_start !== 1'b1 || bus.matrix_a !== B_SEQ) begin errors++; $display("FAIL rstwait fresh frame: start %b matrix_a %h want 1 %h", bus.mult_start, bus.matrix_a, B_SEQ); end
        wait_done(n);
        exp_frames++;
        checks++; if (bus.frame_cnt !== exp_frames) begin errors++; $display("FAIL rstwait frame_cnt: got %0d want %0d", bus.frame_cnt, exp_frames); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync();
        test_timeout();
        test_gaps();
`ifdef MATRIX_LOADER_CKSUM_EN
        test_cksum();
`endif
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish, want finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/matrix_frame_loader.md
# matrix_frame_loader

Upstream feeder for `fast_matrix_mult_3x3`. It accepts a byte stream over a valid/ready handshake and packs the bytes into two row-major 3x3 operand matrices (9 × 8-bit each). It then issues a one-cycle start pulse and holds both operands stable until the multiplier reports `valid_out`. A timeout watchdog recovers the loader if the multiplier never completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32: cycles allowed in WAIT before abandoning a frame; legal range 9..63.

Ports:
- `clk`  in  1  system clock; the block uses this single clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  the upstream byte is valid.
- `in_data`  in  8  stream byte.
- `in_first`  in  1  marks the first byte of a frame; qualified by the handshake.
- `in_ready`  out  1  the loader can accept a byte.
- `mult_start`  out  1  one-cycle start pulse to the multiplier.
- `matrix_a`  out  72  operand A; element j occupies bits [j*8 +: 8], j = row*3+col.
- `matrix_b`  out  72  operand B, same packing as A.
- `mult_valid`  in  1  the multiplier's `valid_out`.
- `busy`  out  1  high in ISSUE and WAIT.
- `frame_cnt`  out  8  count of completed frames; wraps from 255 to 0.
- `err_timeout`  out  1  one-cycle pulse when the watchdog expires.
- `err_cksum`  out  1  one-cycle pulse on checksum mismatch. The port is always present.

## Operation
- States:
  - FILL_A: bytes 0–8.
  - FILL_B: bytes 9–17.
  - CKSUM: byte 18; exists only when the checksum feature is compiled in.
  - ISSUE
  - WAIT
- A byte is accepted when `in_valid && in_ready`. `in_ready = (state ∈ {FILL_A, FILL_B, CKSUM})`, decoded from registered state only.
- Accepted bytes are written into element idx (0–8) of A in FILL_A, or of B in FILL_B. idx resets to 0 on each FILL_A→FILL_B transition.
- Resync: an accepted byte with `in_first=1` in any fill state is stored as A[0]. idx becomes 1 and the state becomes FILL_A. Any partial frame is discarded. `in_first` on a byte that is not accepted has no effect.
- The first byte after reset is accepted as A[0] even if `in_first=0`.
- After the last payload byte is accepted, the next state is ISSUE (or CKSUM when the checksum feature is enabled).
- ISSUE lasts one cycle:
  - `mult_start=1`.
  - The watchdog counter is cleared.
  - The next state is WAIT.
- WAIT:
  - On `mult_valid`: `frame_cnt` increments and the next state is FILL_A.
  - When the counter reaches `TIMEOUT_CYCLES-1` without `mult_valid`: `err_timeout` pulses, `frame_cnt` is unchanged, and the next state is FILL_A.
  - If `mult_valid` and expiry occur in the same cycle, `mult_valid` wins.
- `mult_valid` outside WAIT is ignored.
- `matrix_a` and `matrix_b` are the element registers themselves. They change only on accepted bytes, so they are stable throughout ISSUE and WAIT.

## Timing
- Reset values:
  - All outputs are 0, including `matrix_a`, `matrix_b` and `frame_cnt`.
  - The state is FILL_A, so `in_ready` is 1 one cycle after reset release.
  - A reset mid-frame or mid-WAIT abandons the frame immediately.
- `mult_start` is registered. It is high in the cycle after the final byte (or checksum byte) is accepted.
- The multiplier asserts `mult_valid` 8 cycles after `mult_start`. `in_ready` returns high the cycle after `mult_valid`.
- Minimum frame period is 18 + 1 + 8 + 1 = 28 cycles; with the checksum feature it is 29.
- Back-to-back accepts are sustained: 1 byte per cycle while in the fill states.
- `err_timeout` and `err_cksum` are registered, single-cycle pulses.

## Configuration
- `MATRIX_LOADER_CKSUM_EN` defined:
  - The frame is 19 bytes. Byte 18 must equal the XOR of bytes 0–17.
  - On match: the next state is ISSUE.
  - On mismatch: `err_cksum` pulses, there is no `mult_start`, the next state is FILL_A, and the matrices retain the received (bad) bytes.
- Not defined:
  - The frame is 18 bytes, the CKSUM state is absent, and `err_cksum` is tied to 0.

## Structure
- The package `matrix_loader_pkg` holds:
  - the state enum,
  - `MAT_ELEMS=9`, `ELEM_W=8`,
  - `FRAME_LEN` (18 or 19, selected by the macro).
- No sub-module is needed. The implementation is a single flat module: FSM, index counter, watchdog counter, and XOR accumulator.

## Test plan
- A = [1,0,0,0,1,0,0,0,1] and B = [1..9], with a model multiplier responding after 8 cycles. Required: `matrix_a = 72'h01_00_00_00_01_00_00_00_01`, `matrix_b = 72'h09_08_07_06_05_04_03_02_01`, one `mult_start` pulse, and `frame_cnt` going 0→1.
- Resync: send 5 bytes, then a byte 0xAA with `in_first=1`, then 17 more bytes. Required: A[0]=0xAA and exactly one `mult_start`, occurring after the 18th byte counted from the 0xAA byte.
- `mult_valid` is never returned. Required: `err_timeout` pulses exactly `TIMEOUT_CYCLES` cycles after `mult_start`, `frame_cnt` is unchanged, and `in_ready=1` on the next cycle.
- Random `in_valid` gaps plus a spurious `mult_valid` during FILL_B. Required: packing is identical to the gap-free run and `frame_cnt` is unaffected by the spurious pulse.
- With `MATRIX_LOADER_CKSUM_EN` defined: a correct XOR produces a start; a checksum byte with bit 0 flipped produces an `err_cksum` pulse and no start.
- Assert `rst_n` low during WAIT. Required: all outputs return to 0 asynchronously, and after release a fresh frame completes normally.
